// File: rtl/ifu_imem_axi_slave_if.sv
// Instruction-fetch AXI-lite read channels (AR/R, 64-bit beats) between ifu and its instruction memory slave.
interface ifu_imem_axi_slave_if;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [63:0] ifu_araddr;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [1:0]  ifu_rresp;
  logic [63:0] ifu_rdata;

  modport slave (
    input  ifu_arvalid, ifu_araddr, ifu_rready,
    output ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata
  );

  modport master (
    output ifu_arvalid, ifu_araddr, ifu_rready,
    input  ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata
  );
endinterface

// File: rtl/ifu_imem_axi_slave.sv
// Read-only AXI-lite slave for ifu fetches: queued addresses, range/alignment decode,
// 1-cycle synchronous SRAM read, in-order {rresp,rdata} responses.
module ifu_imem_axi_slave #(
  parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
  parameter int unsigned SIZE_LOG2      = 20,
  parameter int unsigned REQ_DEPTH_LOG2 = 2,
  parameter int unsigned WAIT_CYCLES    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  ifu_imem_axi_slave_if.slave    ifu,
  output logic                   mem_ren,
  output logic [SIZE_LOG2-4:0]   mem_addr,
  input  logic [63:0]            mem_rdata
);

  localparam int unsigned MEM_AW    = SIZE_LOG2 - 3;
  localparam int unsigned RQ_DEPTH  = 1 << REQ_DEPTH_LOG2;
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t state, state_n;
  logic [7:0] wait_cnt, wait_cnt_n;

  // ---------------- request queue ----------------
  logic [63:0]             rq_mem [RQ_DEPTH];
  logic [REQ_DEPTH_LOG2:0] rq_wr, rq_rd;
  logic                    rq_empty, rq_full, rq_push, rq_pop;
  logic [63:0]             rq_head, head_off;
  logic [1:0]              head_resp;

  assign rq_empty = (rq_wr == rq_rd);
  assign rq_full  = (rq_wr[REQ_DEPTH_LOG2] != rq_rd[REQ_DEPTH_LOG2]) &&
                    (rq_wr[REQ_DEPTH_LOG2-1:0] == rq_rd[REQ_DEPTH_LOG2-1:0]);

  assign ifu.ifu_arready = !rst && !rq_full;
  assign rq_push         = ifu.ifu_arvalid && ifu.ifu_arready;

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wr[REQ_DEPTH_LOG2-1:0]] <= ifu.ifu_araddr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_wr <= '0;
      rq_rd <= '0;
    end else begin
      if (rq_push) rq_wr <= rq_wr + 1'b1;
      if (rq_pop)  rq_rd <= rq_rd + 1'b1;
    end
  end

  // Offset wraps modulo 2**64, so addresses below the base land far out of range.
  assign rq_head  = rq_mem[rq_rd[REQ_DEPTH_LOG2-1:0]];
  assign head_off = rq_head - BASE_ADDR;

  always_comb begin
    head_resp = 2'b00;
    if ((head_off >> SIZE_LOG2) != '0) head_resp = 2'b11;
    else if (rq_head[2:0] != 3'b000)   head_resp = 2'b10;
  end

  // ---------------- response queue (2 entries) ----------------
  logic [1:0]  rs_resp [2];
  logic [63:0] rs_data [2];
  logic        rs_wr, rs_rd, rs_push, rs_pop;
  logic [1:0]  rs_cnt;
  logic [1:0]  rs_push_resp;
  logic [63:0] rs_push_data;

  assign ifu.ifu_rvalid = (rs_cnt != 2'd0);
  assign ifu.ifu_rresp  = rs_resp[rs_rd];
  assign ifu.ifu_rdata  = rs_data[rs_rd];
  assign rs_pop         = ifu.ifu_rvalid && ifu.ifu_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_wr   <= 1'b0;
      rs_rd   <= 1'b0;
      rs_cnt  <= 2'd0;
      rs_resp <= '{default: '0};
      rs_data <= '{default: '0};
    end else begin
      if (rs_push) begin
        rs_resp[rs_wr] <= rs_push_resp;
        rs_data[rs_wr] <= rs_push_data;
        rs_wr          <= ~rs_wr;
      end
      if (rs_pop) rs_rd <= ~rs_rd;
      rs_cnt <= rs_cnt + {1'b0, rs_push} - {1'b0, rs_pop};
    end
  end

  // ---------------- service FSM ----------------
  logic addr_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (addr_load) mem_addr <= head_off[SIZE_LOG2-1:3];
    end
  end

  // Starting only when the response queue has room guarantees the DONE push always fits.
  always_comb begin
    state_n      = state;
    wait_cnt_n   = wait_cnt;
    rq_pop       = 1'b0;
    rs_push      = 1'b0;
    rs_push_resp = 2'b00;
    rs_push_data = '0;
    addr_load    = 1'b0;
    mem_ren      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rq_empty && rs_cnt < 2'd2) begin
          if (head_resp != 2'b00) begin
            rs_push      = 1'b1;
            rs_push_resp = head_resp;
            rq_pop       = 1'b1;
          end else if (WAIT_CYCLES != 0) begin
            state_n    = S_WAIT;
            wait_cnt_n = WAIT_INIT;
          end else begin
            state_n   = S_READ;
            addr_load = 1'b1;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_n = wait_cnt - 8'd1;
        if (wait_cnt == 8'd1) begin
          state_n   = S_READ;
          addr_load = 1'b1;
        end
      end
      S_READ: begin
        mem_ren = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        rs_push      = 1'b1;
        rs_push_data = mem_rdata;
        rq_pop       = 1'b1;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, MEM_AW[0]};

endmodule

// File: tb/tb_ifu_imem_axi_slave.sv
// Directed + randomized bench for ifu_imem_axi_slave against a queue-based in-order response model.
module tb_ifu_imem_axi_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_imem_axi_slave_if ifu0 ();
  ifu_imem_axi_slave_if ifu3 ();

  logic        mem_ren0, mem_ren3;
  logic [16:0] mem_addr0, mem_addr3;
  logic [63:0] mem_rdata0, mem_rdata3;

  ifu_imem_axi_slave #(.BASE_ADDR(BASE), .SIZE_LOG2(20), .REQ_DEPTH_LOG2(2), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ifu(ifu0),
    .mem_ren(mem_ren0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
  );

  ifu_imem_axi_slave #(.BASE_ADDR(BASE), .SIZE_LOG2(20), .REQ_DEPTH_LOG2(2), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ifu(ifu3),
    .mem_ren(mem_ren3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [63:0] sram_fn(logic [16:0] idx);
    if (idx == 17'd2) return 64'h1122334455667788;
    return {32'hC0DE_0000 | 32'(idx), ~{15'b0, idx}};
  endfunction

  always @(posedge clk) if (mem_ren0) mem_rdata0 <= sram_fn(mem_addr0);
  always @(posedge clk) if (mem_ren3) mem_rdata3 <= sram_fn(mem_addr3);

  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  resp;
    logic [63:0] data;
  } exp_t;

  function automatic exp_t model(logic [63:0] a);
    exp_t e;
    logic [63:0] off;
    off = a - BASE;
    e.data = '0;
    if (off >= 64'h10_0000)  e.resp = 2'b11;
    else if (a[2:0] != 3'd0) e.resp = 2'b10;
    else begin
      e.resp = 2'b00;
      e.data = sram_fn(off[19:3]);
    end
    return e;
  endfunction

  exp_t       exp_q[$];
  logic [1:0] got_resp[$];
  int         rsp_cnt = 0;
  int         ren_cnt = 0;

  // Scoreboard for dut0: sampled mid-cycle, so each observed valid&ready is a handshake at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (ifu0.ifu_rvalid && ifu0.ifu_rready) begin
        rsp_cnt++;
        got_resp.push_back(ifu0.ifu_rresp);
        if (exp_q.size() == 0) chk("r_unexpected", 64'(exp_q.size()), 64'd1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_rresp", 64'(ifu0.ifu_rresp), 64'(e.resp));
          chk("sb_rdata", ifu0.ifu_rdata, e.data);
        end
      end
      if (ifu0.ifu_arvalid && ifu0.ifu_arready) exp_q.push_back(model(ifu0.ifu_araddr));
      if (mem_ren0) ren_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 3);
    case (k)
      0, 1:    return BASE + {44'b0, 17'($urandom), 3'b000};
      2:       return BASE + {44'b0, 17'($urandom), 3'($urandom_range(1, 7))};
      default: return ($urandom_range(0, 1) != 0) ? BASE + 64'h10_0000 + 64'($urandom_range(0, 255))
                                                   : BASE - 64'($urandom_range(1, 64));
    endcase
  endfunction

  initial begin
    int r0, b0, idx, n;
    logic saw_stall, hs;

    ifu0.ifu_arvalid = 1'b0; ifu0.ifu_araddr = '0; ifu0.ifu_rready = 1'b1;
    ifu3.ifu_arvalid = 1'b0; ifu3.ifu_araddr = '0; ifu3.ifu_rready = 1'b1;
    #12;
    chk("rst_arready", 64'(ifu0.ifu_arready), 64'd0);
    chk("rst_rvalid",  64'(ifu0.ifu_rvalid), 64'd0);
    chk("rst_rresp",   64'(ifu0.ifu_rresp), 64'd0);
    chk("rst_rdata",   ifu0.ifu_rdata, 64'd0);
    chk("rst_mem_ren", 64'(mem_ren0), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr0), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Test 1: single OKAY fetch latency
    ifu0.ifu_arvalid = 1'b1; ifu0.ifu_araddr = BASE + 64'h10;
    chk("t1_arready", 64'(ifu0.ifu_arready), 64'd1);
    tick(); ifu0.ifu_arvalid = 1'b0;
    chk("t1_ren_t1", 64'(mem_ren0), 64'd0);
    chk("t1_rvalid_t1", 64'(ifu0.ifu_rvalid), 64'd0);
    tick();
    chk("t1_ren_t2", 64'(mem_ren0), 64'd1);
    chk("t1_addr_t2", 64'(mem_addr0), 64'd2);
    tick();
    chk("t1_ren_t3", 64'(mem_ren0), 64'd0);
    chk("t1_rvalid_t3", 64'(ifu0.ifu_rvalid), 64'd0);
    tick();
    chk("t1_rvalid_t4", 64'(ifu0.ifu_rvalid), 64'd1);
    chk("t1_rdata", ifu0.ifu_rdata, 64'h1122334455667788);
    chk("t1_rresp", 64'(ifu0.ifu_rresp), 64'd0);
    tick();
    drain("t1_drain");

    // Test 2: back-pressure with 6 back-to-back fetches
    ifu0.ifu_rready = 1'b0;
    r0 = ren_cnt; b0 = rsp_cnt; idx = 0; n = 0; saw_stall = 1'b0;
    ifu0.ifu_arvalid = 1'b1;
    while (idx < 6 && n < 50) begin
      ifu0.ifu_araddr = BASE + 64'(idx * 8);
      hs = ifu0.ifu_arready;
      if (!hs) saw_stall = 1'b1;
      tick();
      if (hs) idx++;
      n++;
    end
    ifu0.ifu_arvalid = 1'b0;
    chk("t2_all_accepted", 64'(idx), 64'd6);
    chk("t2_saw_stall", 64'(saw_stall), 64'd1);
    repeat (8) tick();
    chk("t2_arready_full", 64'(ifu0.ifu_arready), 64'd0);
    chk("t2_rvalid_held", 64'(ifu0.ifu_rvalid), 64'd1);
    chk("t2_head_data", ifu0.ifu_rdata, sram_fn(17'd0));
    chk("t2_reads_stalled", 64'(ren_cnt - r0), 64'd2);
    ifu0.ifu_rready = 1'b1;
    drain("t2_drain");
    chk("t2_rsp_count", 64'(rsp_cnt - b0), 64'd6);

    // Test 3: misaligned fetch
    r0 = ren_cnt;
    ifu0.ifu_arvalid = 1'b1; ifu0.ifu_araddr = BASE + 64'h13;
    tick(); ifu0.ifu_arvalid = 1'b0;
    chk("t3_rvalid_t1", 64'(ifu0.ifu_rvalid), 64'd0);
    tick();
    chk("t3_rvalid_t2", 64'(ifu0.ifu_rvalid), 64'd1);
    chk("t3_rresp", 64'(ifu0.ifu_rresp), 64'd2);
    chk("t3_rdata", ifu0.ifu_rdata, 64'd0);
    tick();
    drain("t3_drain");
    chk("t3_no_ren", 64'(ren_cnt - r0), 64'd0);

    // Test 4: window edges mixed with an OKAY, ordering kept
    r0 = ren_cnt; b0 = got_resp.size();
    ifu0.ifu_arvalid = 1'b1;
    ifu0.ifu_araddr = BASE - 64'd8;          tick();
    ifu0.ifu_araddr = BASE + 64'h10_0000;    tick();
    ifu0.ifu_araddr = BASE + 64'h8;          tick();
    ifu0.ifu_arvalid = 1'b0;
    drain("t4_drain");
    chk("t4_count", 64'(got_resp.size() - b0), 64'd3);
    if (got_resp.size() >= b0 + 3) begin
      chk("t4_resp0", 64'(got_resp[b0]),     64'd3);
      chk("t4_resp1", 64'(got_resp[b0 + 1]), 64'd3);
      chk("t4_resp2", 64'(got_resp[b0 + 2]), 64'd0);
    end
    chk("t4_ren_once", 64'(ren_cnt - r0), 64'd1);

    // Test 5: WAIT_CYCLES=3 instance
    ifu3.ifu_arvalid = 1'b1; ifu3.ifu_araddr = BASE;
    tick(); ifu3.ifu_arvalid = 1'b0;
    repeat (3) tick();
    chk("t5_ren_t4", 64'(mem_ren3), 64'd0);
    tick();
    chk("t5_ren_t5", 64'(mem_ren3), 64'd1);
    chk("t5_addr_t5", 64'(mem_addr3), 64'd0);
    tick();
    chk("t5_rvalid_t6", 64'(ifu3.ifu_rvalid), 64'd0);
    tick();
    chk("t5_rvalid_t7", 64'(ifu3.ifu_rvalid), 64'd1);
    chk("t5_rdata", ifu3.ifu_rdata, sram_fn(17'd0));
    tick();

    // Test 6: reset while a read is in service with 2 queued
    ifu0.ifu_rready = 1'b0;
    ifu0.ifu_arvalid = 1'b1;
    ifu0.ifu_araddr = BASE;          tick();
    ifu0.ifu_araddr = BASE + 64'h8;  tick();
    ifu0.ifu_arvalid = 1'b0;
    chk("t6_in_read", 64'(mem_ren0), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_arready", 64'(ifu0.ifu_arready), 64'd0);
    chk("t6_rvalid", 64'(ifu0.ifu_rvalid), 64'd0);
    chk("t6_mem_ren", 64'(mem_ren0), 64'd0);
    chk("t6_mem_addr", 64'(mem_addr0), 64'd0);
    chk("t6_rdata", ifu0.ifu_rdata, 64'd0);
    chk("t6_rresp", 64'(ifu0.ifu_rresp), 64'd0);
    tick(); tick();
    rst = 1'b0;
    ifu0.ifu_rready = 1'b1;
    saw_stall = 1'b0;
    repeat (4) begin
      tick();
      if (ifu0.ifu_rvalid || mem_ren0) saw_stall = 1'b1;
    end
    chk("t6_no_stale", 64'(saw_stall), 64'd0);
    ifu0.ifu_arvalid = 1'b1; ifu0.ifu_araddr = BASE + 64'h8;
    tick(); ifu0.ifu_arvalid = 1'b0;
    tick();
    chk("t6_ren_t2", 64'(mem_ren0), 64'd1);
    chk("t6_addr_t2", 64'(mem_addr0), 64'd1);
    tick(); tick();
    chk("t6_rvalid_t4", 64'(ifu0.ifu_rvalid), 64'd1);
    chk("t6_rdata_t4", ifu0.ifu_rdata, sram_fn(17'd1));
    tick();
    drain("t6_drain");

    // Randomized traffic against the scoreboard
    b0 = rsp_cnt;
    hs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!ifu0.ifu_arvalid || hs) begin
        ifu0.ifu_arvalid = ($urandom_range(0, 2) != 0);
        ifu0.ifu_araddr  = rand_addr();
      end
      ifu0.ifu_rready = ($urandom_range(0, 3) != 0);
      hs = ifu0.ifu_arvalid && ifu0.ifu_arready;
      tick();
    end
    ifu0.ifu_arvalid = 1'b0;
    ifu0.ifu_rready  = 1'b1;
    drain("rand_drain");
    chk("rand_progress", 64'(rsp_cnt - b0 > 50), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
